// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, imem/dmem wait.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/flush counters; outputs are combinational from state + inputs.
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic        id_rs_used,
  input  logic [4:0]  id_rt,
  input  logic        id_rt_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        id_branch_taken,
  input  logic        imem_ready,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        pc_ce,
  output logic        if_id_ce,
  output logic        if_id_flush,
  output logic        id_ex_ce,
  output logic        id_ex_bubble,
  output logic        ex_mem_ce,
  output logic        mem_wb_bubble,
  output logic [1:0]  state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    DMEM_WAIT  = 2'd2,
    IMEM_WAIT  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d, ret_q, ret_d, eval_st;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard, dwait;
  logic             pc_ce_c, if_id_ce_c, if_id_flush_c, id_ex_ce_c;
  logic             id_ex_bubble_c, ex_mem_ce_c, mem_wb_bubble_c, br_flush_c;

  assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));
  assign dwait  = mem_access && !dmem_ready;
  // Once the data wait clears, the cycle behaves as whatever state it interrupted.
  assign eval_st = (state_q == DMEM_WAIT) ? ret_q : state_q;

  always_comb begin
    state_d         = state_q;
    ret_d           = ret_q;
    cnt_d           = cnt_q;
    pc_ce_c         = 1'b1;
    if_id_ce_c      = 1'b1;
    if_id_flush_c   = 1'b0;
    id_ex_ce_c      = 1'b1;
    id_ex_bubble_c  = 1'b0;
    ex_mem_ce_c     = 1'b1;
    mem_wb_bubble_c = 1'b0;
    br_flush_c      = 1'b0;
    if (dwait) begin
      pc_ce_c         = 1'b0;
      if_id_ce_c      = 1'b0;
      id_ex_ce_c      = 1'b0;
      ex_mem_ce_c     = 1'b0;
      mem_wb_bubble_c = 1'b1;
      if (state_q != DMEM_WAIT) begin
        ret_d   = state_q;
        state_d = DMEM_WAIT;
      end
    end else if (hazard || (eval_st == LOAD_STALL)) begin
      pc_ce_c        = 1'b0;
      if_id_ce_c     = 1'b0;
      id_ex_bubble_c = 1'b1;
      if (eval_st == LOAD_STALL) begin
        if (cnt_q == CNT_ONE) begin
          state_d = RUN;
        end else begin
          state_d = LOAD_STALL;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end else if (LOAD_STALL_CYCLES > 1) begin
        state_d = LOAD_STALL;
        cnt_d   = CNT_INIT;
      end else begin
        state_d = eval_st;
      end
    end else if (id_branch_taken) begin
      if_id_flush_c = 1'b1;
      br_flush_c    = 1'b1;
      state_d       = RUN;
    end else if (!imem_ready) begin
      pc_ce_c       = 1'b0;
      if_id_flush_c = 1'b1;
      state_d       = IMEM_WAIT;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_ce         = pc_ce_c & ~rst;
  assign if_id_ce      = if_id_ce_c & ~rst;
  assign if_id_flush   = if_id_flush_c & ~rst;
  assign id_ex_ce      = id_ex_ce_c & ~rst;
  assign id_ex_bubble  = id_ex_bubble_c & ~rst;
  assign ex_mem_ce     = ex_mem_ce_c & ~rst;
  assign mem_wb_bubble = mem_wb_bubble_c & ~rst;
  assign state         = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_ce_c && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (br_flush_c && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif

endmodule
